// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Scan-image bit 4*col+row marks a pressed key; KEYMAP translates that index to its code.
package keypad_pkg;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned KEYS   = ROWS * COLS;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned COL_W  = 2;
  localparam int unsigned CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_REL
  } deb_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_KEY,
    SCAN_MULTI
  } scan_res_e;

  // Entry 15 first: c3 {D,C,B,A}, c2 {F,9,6,3}, c1 {0,8,5,2}, c0 {E,7,4,1} (rows 3..0)
  localparam logic [KEYS-1:0][CODE_W-1:0] KEYMAP = {
    4'hD, 4'hC, 4'hB, 4'hA,
    4'hF, 4'h9, 4'h6, 4'h3,
    4'h0, 4'h8, 4'h5, 4'h2,
    4'hE, 4'h7, 4'h4, 4'h1
  };

endpackage

// File: rtl/keypad_bcd_scanner_if.sv
// Keypad pins plus the key-code valid/ack handshake toward the consumer.
interface keypad_bcd_scanner_if;
  import keypad_pkg::*;

  logic [ROWS-1:0]   row_n;
  logic [COLS-1:0]   col_n;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ack;
  logic              key_down;
  logic              overrun;

  modport master (
    input  row_n, key_ack,
    output col_n, key_code, key_valid, key_down, overrun
  );

  modport slave (
    output row_n, key_ack,
    input  col_n, key_code, key_valid, key_down, overrun
  );

endinterface

// File: rtl/keypad_col_scan.sv
// Column driver, row synchronizer and scan-image capture.
// o_scan_done pulses for one clock once the image holds a complete 4-column scan.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] i_row_n,
  output logic [COLS-1:0] o_col_n,
  output logic [KEYS-1:0] o_image,
  output logic            o_scan_done
);

  localparam int unsigned       SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);

  logic [ROWS-1:0]   r_row_meta;
  logic [ROWS-1:0]   r_row_sync;
  logic [SLOT_W-1:0] r_slot;
  logic [COL_W-1:0]  r_col;
  logic [COLS-1:0]   r_col_n;
  logic [KEYS-1:0]   r_image;
  logic              r_scan_done;
  logic              w_slot_last;

  assign w_slot_last = (r_slot == SLOT_LAST);

  // Rows idle high through the pull-ups, so the synchronizer resets to all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= '1;
      r_row_sync <= '1;
    end else begin
      r_row_meta <= i_row_n;
      r_row_sync <= r_row_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot  <= '0;
      r_col   <= '0;
      r_col_n <= 4'b1110;
    end else if (w_slot_last) begin
      r_slot  <= '0;
      r_col   <= r_col + COL_W'(1);
      r_col_n <= {r_col_n[COLS-2:0], r_col_n[COLS-1]};
    end else begin
      r_slot  <= r_slot + SLOT_W'(1);
    end
  end

  // Rows are sampled at the end of the slot, long after the synchronizer has settled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_image     <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= w_slot_last && (r_col == COL_LAST);
      if (w_slot_last) begin
        r_image[{r_col, 2'b00} +: ROWS] <= ~r_row_sync;
      end
    end
  end

  assign o_col_n     = r_col_n;
  assign o_image     = r_image;
  assign o_scan_done = r_scan_done;

endmodule

// File: rtl/keypad_bcd_scanner.sv
// 4x4 keypad scanner: classifies each full scan, debounces press/release,
// and presents accepted key codes through a sticky valid/ack handshake.
module keypad_bcd_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 5
) (
  input logic                  clk,
  input logic                  rst,
  keypad_bcd_scanner_if.master kp
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [COLS-1:0]   w_col_n;
  logic [KEYS-1:0]   w_image;
  logic              w_scan_done;
  scan_res_e         w_result;
  logic [IDX_W-1:0]  w_key_idx;
  logic              w_is_key;
  logic [CNT_W-1:0]  w_cnt_inc;

  deb_state_e        r_state;
  deb_state_e        w_state_nxt;
  logic [IDX_W-1:0]  r_cand;
  logic [IDX_W-1:0]  w_cand_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_accept;
  logic              w_ack_hit;

  logic [CODE_W-1:0] r_key_code;
  logic              r_key_valid;
  logic              r_key_down;
  logic              r_overrun;

  keypad_col_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_col_scan (
    .clk        (clk),
    .rst        (rst),
    .i_row_n    (kp.row_n),
    .o_col_n    (w_col_n),
    .o_image    (w_image),
    .o_scan_done(w_scan_done)
  );

  // Multiple simultaneous keys are reported as MULTI and debounced like no key
  always_comb begin
    w_result = SCAN_NONE;
    if ($onehot(w_image)) begin
      w_result = SCAN_KEY;
    end else if (|w_image) begin
      w_result = SCAN_MULTI;
    end
  end

  always_comb begin
    w_key_idx = '0;
    for (int unsigned i = 0; i < KEYS; i++) begin
      if (w_image[i]) begin
        w_key_idx = IDX_W'(i);
      end
    end
  end

  assign w_is_key  = (w_result == SCAN_KEY);
  assign w_cnt_inc = (r_cnt >= CNT_DONE) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_ack_hit = kp.key_ack & r_key_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    if (w_scan_done) begin
      case (r_state)
        IDLE: begin
          if (w_is_key) begin
            w_cand_nxt  = w_key_idx;
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (!w_is_key) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else if (w_key_idx != r_cand) begin
            w_cand_nxt  = w_key_idx;
            w_cnt_nxt   = CNT_ONE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_DONE) begin
              w_accept    = 1'b1;
              w_state_nxt = PRESSED;
            end
          end
        end
        // Rollover to a different key stays here until everything is released
        PRESSED: begin
          if (!w_is_key) begin
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = DEB_REL;
          end
        end
        DEB_REL: begin
          if (w_is_key) begin
            w_state_nxt = PRESSED;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_DONE) begin
              w_cnt_nxt   = '0;
              w_state_nxt = IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // A fresh accept beats a same-cycle ack; the ack still consumes the older key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_key_down <= (w_state_nxt == PRESSED) || (w_state_nxt == DEB_REL);
      if (w_accept) begin
        r_key_code  <= KEYMAP[r_cand];
        r_key_valid <= 1'b1;
        r_overrun   <= w_ack_hit ? 1'b0 : (r_overrun | r_key_valid);
      end else if (w_ack_hit) begin
        r_key_valid <= 1'b0;
        r_overrun   <= 1'b0;
      end
    end
  end

  assign kp.col_n     = w_col_n;
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_down  = r_key_down;
  assign kp.overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_bcd_scanner.sv
// Bench for keypad_bcd_scanner: a keypad matrix model drives the rows, and a
// run-length model of press/release acceptance predicts every output each cycle.
module tb_keypad_bcd_scanner;
  import keypad_pkg::*;

  localparam int unsigned DIV  = 4;
  localparam int unsigned DEB  = 3;
  localparam int unsigned SCAN = 4 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ack = 1'b0;
  logic [3:0][3:0] keys = '0;   // keys[row][col]

  int n_checks = 0;
  int n_err    = 0;

  keypad_bcd_scanner_if kif();

  keypad_bcd_scanner #(
    .SCAN_DIV      (DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kif)
  );

  always #5 clk = ~clk;

  assign kif.key_ack = ack;

  // Passive matrix: a row reads low while a pressed key connects it to the driven column
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      kif.row_n[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (keys[r][c] && !kif.col_n[c]) kif.row_n[r] = 1'b0;
      end
    end
  end

  // Keypad legend as printed, row-major
  int code_tbl [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  int       e        = 0;
  int       run_val  = -2;
  int       run_len  = 0;
  bit       held     = 1'b0;
  bit       pend     = 1'b0;
  int       pend_val = -1;
  bit       m_valid  = 1'b0;
  bit       m_over   = 1'b0;
  bit [3:0] m_code   = 4'h0;

  // Reference: a scan's result is the matrix held during that scan, acted on the clock after the scan ends
  always @(posedge clk) begin
    bit acc;
    int cnt;
    int val;
    acc = 1'b0;
    if (rst) begin
      e = 0; run_val = -2; run_len = 0; held = 1'b0; pend = 1'b0;
      m_valid = 1'b0; m_over = 1'b0; m_code = 4'h0;
    end else begin
      e++;
      if (pend) begin
        pend = 1'b0;
        if (pend_val == run_val) run_len++;
        else begin run_val = pend_val; run_len = 1; end
        if (!held && pend_val >= 0 && run_len == DEB) begin
          held = 1'b1;
          acc  = 1'b1;
        end else if (held && pend_val < 0 && run_len == DEB) begin
          held = 1'b0;
        end
      end
      if (acc) begin
        m_over  = (ack && m_valid) ? 1'b0 : (m_over | m_valid);
        m_valid = 1'b1;
        m_code  = 4'(run_val);
      end else if (ack && m_valid) begin
        m_valid = 1'b0;
        m_over  = 1'b0;
      end
      if (e % SCAN == 0) begin
        cnt = 0; val = -1;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            if (keys[r][c]) begin cnt++; val = code_tbl[r][c]; end
        pend_val = (cnt == 1) ? val : -1;
        pend     = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] exp_col;
    if (!rst) begin
      exp_col = 4'hF ^ (4'h1 << ((e / DIV) % 4));
      chk("col_n",     kif.col_n,         exp_col);
      chk("key_code",  kif.key_code,      m_code);
      chk("key_valid", 4'(kif.key_valid), 4'(m_valid));
      chk("key_down",  4'(kif.key_down),  4'(held));
      chk("overrun",   4'(kif.overrun),   4'(m_over));
    end
  end

  function automatic logic [3:0][3:0] key1(input int r, input int c);
    logic [3:0][3:0] k;
    k = '0;
    k[r][c] = 1'b1;
    return k;
  endfunction

  task automatic scans(input logic [3:0][3:0] k, input int n);
    keys = k;
    repeat (n * SCAN) @(negedge clk);
  endtask

  // One scan with a single-cycle ack; checks key_valid just before and one clock after it
  task automatic scan_ack(input logic [3:0][3:0] k, input int at, input bit exp_after);
    keys = k;
    repeat (at) @(negedge clk);
    chk("valid_before_ack", 4'(kif.key_valid), 4'h1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("valid_after_ack", 4'(kif.key_valid), 4'(exp_after));
    repeat (SCAN - at - 1) @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_col_n",   kif.col_n,         4'b1110);
    chk("rst_code",    kif.key_code,      4'h0);
    chk("rst_valid",   4'(kif.key_valid), 4'h0);
    chk("rst_down",    4'(kif.key_down),  4'h0);
    chk("rst_overrun", 4'(kif.overrun),   4'h0);
  endtask

  initial begin
    logic [3:0] col_tbl [4];
    logic [3:0][3:0] k2;
    col_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    repeat (2) @(negedge clk);
    #1 chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;

    // Idle rotation, 4 clocks per column
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("col_seq", kif.col_n, col_tbl[(i / 4) % 4]);
      chk("idle_valid", 4'(kif.key_valid), 4'h0);
    end

    // Stable r2c1
    scans(key1(2, 1), 4);
    chk("r2c1_code", kif.key_code, 4'h8);
    chk("r2c1_valid", 4'(kif.key_valid), 4'h1);
    chk("r2c1_down", 4'(kif.key_down), 4'h1);
    scan_ack(key1(2, 1), 5, 1'b0);
    scans('0, 4);
    chk("r2c1_released", 4'(kif.key_down), 4'h0);

    // Bouncing r0c0 with a stray neighbour, then stable
    scans(key1(0, 0), 1);
    scans('0, 1);
    scans(key1(0, 1), 1);
    scans(key1(0, 0), 4);
    chk("bounce_code", kif.key_code, 4'h1);
    chk("bounce_valid", 4'(kif.key_valid), 4'h1);
    chk("bounce_single", 4'(kif.overrun), 4'h0);
    scan_ack(key1(0, 0), 3, 1'b0);
    scans('0, 4);

    // Two presses without ack
    scans(key1(3, 0), 4);
    chk("star_code", kif.key_code, 4'hE);
    scans('0, 4);
    scans(key1(3, 2), 4);
    chk("hash_code", kif.key_code, 4'hF);
    chk("hash_valid", 4'(kif.key_valid), 4'h1);
    chk("hash_overrun", 4'(kif.overrun), 4'h1);
    scan_ack(key1(3, 2), 2, 1'b0);
    chk("ack_clr_overrun", 4'(kif.overrun), 4'h0);
    scans('0, 4);

    // Two keys in one row, then one released
    k2 = key1(1, 3) | key1(1, 0);
    scans(k2, 4);
    chk("multi_down", 4'(kif.key_down), 4'h0);
    chk("multi_valid", 4'(kif.key_valid), 4'h0);
    scans(key1(1, 3), 4);
    chk("b_code", kif.key_code, 4'hB);
    chk("b_valid", 4'(kif.key_valid), 4'h1);
    scans('0, 4);

    // Accept coincides with ack of the pending B
    scans(key1(0, 3), 3);
    scan_ack(key1(0, 3), 0, 1'b1);
    chk("coll_code", kif.key_code, 4'hA);
    chk("coll_valid", 4'(kif.key_valid), 4'h1);
    chk("coll_overrun", 4'(kif.overrun), 4'h0);
    scan_ack(key1(0, 3), 2, 1'b0);
    scans('0, 4);

    // Reset in the middle of debouncing a press
    scans(key1(2, 2), 2);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    scans(key1(2, 2), 3);
    chk("post_rst_wait", 4'(kif.key_valid), 4'h0);
    scans(key1(2, 2), 1);
    chk("post_rst_code", kif.key_code, 4'h9);
    chk("post_rst_valid", 4'(kif.key_valid), 4'h1);
    scan_ack(key1(2, 2), 2, 1'b0);
    scans('0, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/keypad_bcd_scanner.md
# keypad_bcd_scanner

Scans a 4x4 matrix keypad one column at a time, debounces the result, and delivers each new key as a 4-bit hex/BCD code with a valid/ack handshake. It is the input-side counterpart of the BCD-to-seven-segment display path: its `key_code` feeds the display digit registers directly.

## Interface
- `SCAN_DIV`, 50000: clocks each column is driven (1 ms at 50 MHz); must be ≥ 4.
- `DEBOUNCE_SCANS`, 5: consecutive identical full-scan results required to accept a press or a release; must be ≥ 2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `row_n` in 4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_n` out 4: column drive, active-low, exactly one bit low at any time.
- `key_code` out 4: code of the last accepted key.
- `key_valid` out 1: new key pending; held until acknowledged.
- `key_ack` in 1: consumer acknowledge.
- `key_down` out 1: a debounced key is currently held.
- `overrun` out 1: sticky; a press was accepted while `key_valid` was already set.

## Operation
- `row_n` passes through a 2-flop synchronizer before any use.
- Column scan:
  - Slot counter counts 0..SCAN_DIV-1, then column index c advances 0→1→2→3→0.
  - `col_n` = ~(1<<c).
  - Synchronized rows are sampled in the last clock of each slot, into bits [4c+3:4c] of a 16-bit scan image.
  - After column 3 is sampled, a full-scan result is produced: NONE (no bits set), KEY(k) (exactly one bit set), or MULTI (two or more bits set; treated as NONE).
- Keymap, row r / column c, codes given as r0c0..r0c3 etc.:
  - row 0: 1, 2, 3, A
  - row 1: 4, 5, 6, B
  - row 2: 7, 8, 9, C
  - row 3: E (*), 0, F (#), D
- Debounce FSM, evaluated once per full-scan result:
  - IDLE: KEY(k) → cand=k, cnt=1, DEB_PRESS. Otherwise stay.
  - DEB_PRESS:
    - KEY(cand) → cnt+1; when cnt reaches DEBOUNCE_SCANS → accept, PRESSED.
    - KEY(other) → cand=new, cnt=1.
    - NONE/MULTI → IDLE.
  - PRESSED: NONE/MULTI → cnt=1, DEB_REL. KEY(any) → stay; a rollover to another key is ignored until release.
  - DEB_REL:
    - NONE/MULTI → cnt+1; at DEBOUNCE_SCANS → IDLE.
    - KEY(any) → PRESSED.
- Accept action: `key_code`←cand; `key_valid`←1; if `key_valid` was already 1, `overrun`←1.
- `key_down` = 1 in PRESSED and DEB_REL.
- `key_ack` while `key_valid`=1 clears `key_valid` and `overrun` next clock. `key_ack` while `key_valid`=0 is ignored.
- Counter widths: slot = $clog2(SCAN_DIV); debounce = $clog2(DEBOUNCE_SCANS+1). The debounce counter saturates and never wraps.

## Timing
- Reset values: `col_n`=4'b1110, `key_code`=0, `key_valid`=0, `key_down`=0, `overrun`=0, FSM=IDLE, counters=0, scan image=0.
- One full scan takes 4·SCAN_DIV clocks.
- A row change reaches the sample point 2 clocks later (synchronizer delay).
- Press latency: `key_valid` rises 1 clock after the DEBOUNCE_SCANS-th matching scan result. `key_down` rises in the same clock.
- Release: `key_down` falls 1 clock after the DEBOUNCE_SCANS-th NONE result.
- Accept and `key_ack` in the same clock: accept wins. `key_valid` stays 1, `key_code` updates, `overrun`=0.
- `rst` asserted mid-scan or mid-debounce returns everything to reset values immediately; no key is reported.

## Structure
- Package `keypad_pkg`:
  - FSM state enum (IDLE, DEB_PRESS, PRESSED, DEB_REL).
  - Scan result enum (NONE, KEY, MULTI).
  - 16-entry keymap constant.
- Sub-module `keypad_col_scan`: slot divider, column rotation, synchronizer, and 16-bit scan-image capture. Outputs the image plus a 1-clock `scan_done` strobe.
- Top level: result classification, debounce FSM, handshake registers.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3.
- Reset, no keys → `col_n` cycles 1110, 1101, 1011, 0111 with 4 clocks per column. `key_valid` stays 0.
- Hold r2c1 stable → after 3 scans, `key_code`=8 and `key_valid`=1. It stays 1 until `key_ack`, then drops 1 clock later.
- r0c0 bouncing (toggled within the first 2 scans), then stable → exactly one accept, `key_code`=1.
- Press r3c0, release, then press r3c2 without ack → `key_code`=F, `key_valid`=1, `overrun`=1. `key_ack` clears both.
- Hold r1c3 and r1c0 together → MULTI; no accept and `key_down`=0. Release r1c0 → `key_code`=B after 3 scans.
- Assert `rst` with cnt=2 in DEB_PRESS → all outputs return to reset values. After release of `rst`, the held key needs 3 fresh scans to be accepted.
